// File: rtl/alu_seq_unit.sv
// alu_seq_unit: sequential ALU with a valid/ready request and result handshake.
// Single-cycle ops go straight to DONE. SLLV/SRLV shift one bit per EXEC cycle.
// Optional feature macro: ALU_SEQ_MUL_EN enables a shift-add MUL that takes
// WIDTH EXEC cycles. Without the macro, funct 011000 is an undefined op.
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL, OP_MUL, OP_BAD
  } op_t;

  state_t           state, state_next;
  op_t              op_dec, op_reg;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             long_op;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] exec_val;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
`endif

  assign shamt  = b[SHW-1:0];
  assign accept = in_valid && (state == IDLE);

  // Decode aluop/funct into an internal operation code.
  always_comb begin
    op_dec = OP_BAD;
    if (aluop == 2'b00) begin
      op_dec = OP_ADD;
    end else if (aluop == 2'b01) begin
      op_dec = OP_SUB;
    end else begin
      case (funct)
        6'b100000: op_dec = OP_ADD;
        6'b100010: op_dec = OP_SUB;
        6'b100100: op_dec = OP_AND;
        6'b100101: op_dec = OP_OR;
        6'b101010: op_dec = OP_SLT;
        6'b000100: op_dec = OP_SLL;
        6'b000110: op_dec = OP_SRL;
`ifdef ALU_SEQ_MUL_EN
        6'b011000: op_dec = OP_MUL;
`endif
        default:   op_dec = OP_BAD;
      endcase
    end
  end

  // Multi-cycle ops are non-zero shifts and MUL; everything else finishes at accept.
  assign long_op = (((op_dec == OP_SLL) || (op_dec == OP_SRL)) && (shamt != '0)) ||
                   (op_dec == OP_MUL);

  // Value loaded into the result register at acceptance.
  always_comb begin
    load_val = '0;
    case (op_dec)
      OP_ADD:         load_val = a + b;
      OP_SUB:         load_val = a - b;
      OP_AND:         load_val = a & b;
      OP_OR:          load_val = a | b;
      OP_SLT:         load_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL, OP_SRL: load_val = a;
      default:        load_val = '0;
    endcase
  end

  // Value the result register takes on each EXEC iteration.
  always_comb begin
    exec_val = result;
    case (op_reg)
      OP_SLL:  exec_val = result << 1;
      OP_SRL:  exec_val = result >> 1;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  exec_val = mplier[0] ? (result + mcand) : result;
`endif
      default: exec_val = result;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = long_op ? EXEC : DONE;
      end
      EXEC: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands at accept, iterate in EXEC, hold otherwise.
  // The counter is loaded with iterations-1 so it fits in SHW bits for both
  // shifts (up to WIDTH-1 steps) and MUL (WIDTH steps).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
      op_reg <= OP_ADD;
`ifdef ALU_SEQ_MUL_EN
      mcand  <= '0;
      mplier <= '0;
`endif
    end else if (accept) begin
      result <= load_val;
      zero   <= (load_val == '0);
      err    <= (op_dec == OP_BAD);
      op_reg <= op_dec;
      cnt    <= (op_dec == OP_MUL) ? SHW'(WIDTH-1) : (shamt - SHW'(1));
`ifdef ALU_SEQ_MUL_EN
      mcand  <= a;
      mplier <= b;
`endif
    end else if (state == EXEC) begin
      result <= exec_val;
      zero   <= (exec_val == '0);
      cnt    <= cnt - SHW'(1);
`ifdef ALU_SEQ_MUL_EN
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed stimulus with literal expectations, plus a
// queue-based transaction model checked by a compare process every cycle.
// Build with or without ALU_SEQ_MUL_EN; MUL expectations follow the macro.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  aluop = 2'b00;
  logic [5:0]  funct = 6'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        err;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          due;
  } exp_t;

  exp_t q[$];

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what a request must produce, from the op definitions.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   n;
    e.res = 32'd0; e.err = 1'b0; e.lat = 1; e.due = 0;
    n = int'(y[4:0]);
    if (op == 2'b00)      e.res = x + y;
    else if (op == 2'b01) e.res = x - y;
    else begin
      case (fn)
        6'b100000: e.res = x + y;
        6'b100010: e.res = x - y;
        6'b100100: e.res = x & y;
        6'b100101: e.res = x | y;
        6'b101010: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        6'b000100: begin e.res = x << n; e.lat = n + 1; end
        6'b000110: begin e.res = x >> n; e.lat = n + 1; end
`ifdef ALU_SEQ_MUL_EN
        6'b011000: begin e.res = x * y; e.lat = 33; end
`endif
        default:   e.err = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Compare process: every negedge, check handshake outputs and, while a
  // result is due, its value against the model queue.
  initial begin : compare
    bit   was_empty;
    bit   exp_v;
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        q.delete();
      end else begin
        was_empty = (q.size() == 0);
        exp_v = !was_empty && (ncyc >= q[0].due);
        chk("cmp in_ready", {63'd0, in_ready}, {63'd0, was_empty});
        chk("cmp out_valid", {63'd0, out_valid}, {63'd0, exp_v});
        if (exp_v && out_valid) begin
          chk("cmp result", {32'd0, result}, {32'd0, q[0].res});
          chk("cmp zero", {63'd0, zero}, {63'd0, (q[0].res == 32'd0)});
          chk("cmp err", {63'd0, err}, {63'd0, q[0].err});
        end
        if (exp_v && out_ready) void'(q.pop_front());
        if (was_empty && in_valid) begin
          e = model(aluop, funct, a, b);
          e.due = ncyc + e.lat;
          q.push_back(e);
        end
      end
    end
  end

  // One request from idle to completed handshake, with literal expectations.
  // Called and returns at 1 time unit after a rising edge, with the DUT idle.
  task automatic run(input string name, input logic [1:0] op, input logic [5:0] fn,
                     input logic [31:0] x, input logic [31:0] y, input int stall,
                     input bit hold_valid, input logic [31:0] exp_res,
                     input logic exp_err, input int exp_lat);
    int lat;
    aluop = op; funct = fn; a = x; b = y; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    // Operands must not be sampled after acceptance.
    a = $urandom; b = $urandom; funct = 6'($urandom);
    if (!hold_valid) in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    $display("op %s: a=%0h b=%0h result=%0h zero=%0b err=%0b latency=%0d",
             name, x, y, result, zero, err, lat);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " result"}, {32'd0, result}, {32'd0, exp_res});
    chk({name, " zero"}, {63'd0, zero}, {63'd0, (exp_res == 32'd0)});
    chk({name, " err"}, {63'd0, err}, {63'd0, exp_err});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({name, " stall out_valid"}, {63'd0, out_valid}, 64'd1);
      chk({name, " stall result"}, {32'd0, result}, {32'd0, exp_res});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, " in_ready after"}, {63'd0, in_ready}, 64'd1);
    chk({name, " out_valid after"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #1;
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset result", {32'd0, result}, 64'd0);
    chk("reset zero", {63'd0, zero}, 64'd0);
    chk("reset err", {63'd0, err}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run("sub_eq",   2'b10, 6'b100010, 32'd5, 32'd5, 0, 1'b0, 32'd0, 1'b0, 1);
    run("slt_neg",  2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 0, 1'b0, 32'd1, 1'b0, 1);
    run("slt_swap", 2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 0, 1'b0, 32'd0, 1'b0, 1);
    run("sllv3",    2'b10, 6'b000100, 32'd1, 32'h00000123, 0, 1'b1, 32'd8, 1'b0, 4);
    run("undef",    2'b10, 6'b111111, 32'h1234, 32'h5678, 0, 1'b0, 32'd0, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
    run("mul",      2'b10, 6'b011000, 32'd7, 32'd6, 5, 1'b0, 32'd42, 1'b0, 33);
`else
    run("mul_off",  2'b10, 6'b011000, 32'd7, 32'd6, 0, 1'b0, 32'd0, 1'b1, 1);
`endif
    run("add_wrap", 2'b00, 6'b000000, 32'hFFFFFFFF, 32'd2, 0, 1'b0, 32'd1, 1'b0, 1);
    run("sub_wrap", 2'b01, 6'b111111, 32'd0, 32'd1, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 1);
    run("and",      2'b10, 6'b100100, 32'hF0F01234, 32'h0FF0FF00, 0, 1'b0, 32'h00F01200, 1'b0, 1);
    run("or",       2'b11, 6'b100101, 32'hF0000000, 32'h0000000F, 0, 1'b0, 32'hF000000F, 1'b0, 1);
    run("srlv31",   2'b10, 6'b000110, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 32'd1, 1'b0, 32);
    run("sllv0",    2'b10, 6'b000100, 32'hDEADBEEF, 32'h00000020, 0, 1'b0, 32'hDEADBEEF, 1'b0, 1);
    run("add_stall",2'b10, 6'b100000, 32'd3, 32'd4, 2, 1'b0, 32'd7, 1'b0, 1);

    // Abort a long operation with reset while it is in EXEC.
    aluop = 2'b10;
`ifdef ALU_SEQ_MUL_EN
    funct = 6'b011000; a = 32'd7; b = 32'd6;
`else
    funct = 6'b000100; a = 32'd1; b = 32'd31;
`endif
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("op reset_abort: in_ready=%0b out_valid=%0b", in_ready, out_valid);
    chk("abort in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("abort no stale out_valid", {63'd0, out_valid}, 64'd0);
    end
    run("post_reset", 2'b10, 6'b100000, 32'd10, 32'd20, 0, 1'b0, 32'd30, 1'b0, 1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
